// File: rtl/cpu_pkg.sv
// Shared CPU types: fetch FSM states, instruction-queue entry and the nop encoding.
package cpu_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH      = 2'd0,
        WAIT_SPACE = 2'd1,
        DISCARD    = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small circular instruction queue (DEPTH must be a power of two) with flush priority.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  fetch_entry_t                 push_data,
    input  logic                         pop,
    input  logic                         flush,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output fetch_entry_t                 head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    // A push into a full queue is only legal when the head leaves in the same cycle.
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding imem request at a time, feeding fetch_queue.
// Defining FETCH_PERF_CNT_EN adds saturating stall-cycle and flush counters.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        br_taken,
    input  logic [31:0] br_pc,
    input  logic [15:0] br_imm16,
    input  logic        stall,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cyc,
    output logic [31:0] perf_flush_cnt
`endif
);

    localparam int CW = $clog2(QDEPTH + 1);

    fetch_state_t  state;
    fetch_state_t  state_nxt;
    logic [31:0]   fetch_pc;
    logic [31:0]   fetch_pc_nxt;
    logic [31:0]   target_pc;
    logic [31:0]   target_pc_nxt;
    logic [31:0]   br_target;
    logic          push;
    logic          pop;
    logic          fills;
    logic          q_full;
    logic          q_empty;
    logic [CW-1:0] q_count;
    fetch_entry_t  q_head;
    fetch_entry_t  push_data;

    assign br_target  = br_pc + 32'd4 + {{14{br_imm16[15]}}, br_imm16, 2'b00};
    assign pop        = !q_empty && !stall && !br_taken;
    assign fills      = (q_count == CW'(QDEPTH - 1) && !pop) || (q_full && pop);
    assign push_data  = '{pc: fetch_pc, inst: imem_rdata};
    assign imem_addr  = fetch_pc;
    assign inst_valid = !q_empty;
    assign inst       = q_empty ? NOP_INST : q_head.inst;
    assign inst_pc    = q_empty ? 32'h0 : q_head.pc;

    fetch_queue #(.DEPTH(QDEPTH)) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (br_taken),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count),
        .head      (q_head)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= FETCH;
            fetch_pc  <= RESET_PC;
            target_pc <= RESET_PC;
        end else begin
            state     <= state_nxt;
            fetch_pc  <= fetch_pc_nxt;
            target_pc <= target_pc_nxt;
        end
    end

    // In DISCARD fetch_pc keeps the in-flight address; the redirect waits in target_pc.
    always_comb begin
        state_nxt     = state;
        fetch_pc_nxt  = fetch_pc;
        target_pc_nxt = target_pc;
        push          = 1'b0;
        imem_req      = 1'b0;
        case (state)
            FETCH: begin
                imem_req = 1'b1;
                if (br_taken) begin
                    if (imem_ack) begin
                        fetch_pc_nxt = br_target;
                    end else begin
                        target_pc_nxt = br_target;
                        state_nxt     = DISCARD;
                    end
                end else if (imem_ack) begin
                    push         = 1'b1;
                    fetch_pc_nxt = fetch_pc + 32'd4;
                    if (fills) state_nxt = WAIT_SPACE;
                end
            end
            WAIT_SPACE: begin
                if (br_taken) begin
                    fetch_pc_nxt = br_target;
                    state_nxt    = FETCH;
                end else if (pop) begin
                    state_nxt = FETCH;
                end
            end
            DISCARD: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    fetch_pc_nxt = br_taken ? br_target : target_pc;
                    state_nxt    = FETCH;
                end else if (br_taken) begin
                    target_pc_nxt = br_target;
                end
            end
            default: state_nxt = FETCH;
        endcase
        if (reset) imem_req = 1'b0;
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_cyc <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stall && inst_valid && perf_stall_cyc != '1) perf_stall_cyc <= perf_stall_cyc + 32'd1;
            if (br_taken && perf_flush_cnt != '1)            perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit (QDEPTH=2): cycle-by-cycle directed vector table
// followed by hand-written streaming and queue-full sequences.
module tb_fetch_unit;

    typedef struct {
        logic        rst;
        logic        ack;
        logic [31:0] rdata;
        logic        br;
        logic [31:0] brpc;
        logic [15:0] imm;
        logic        stl;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_inst;
        logic [31:0] exp_pc;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        br_taken;
    logic [31:0] br_pc;
    logic [15:0] br_imm16;
    logic        stall;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_stall_cyc;
    logic [31:0] perf_flush_cnt;
`endif

    int   n_compared;
    int   n_mismatched;
    vec_t vecs[$];

    localparam logic [31:0] I0 = 32'hA000_0000;
    localparam logic [31:0] I1 = 32'hA000_0004;
    localparam logic [31:0] I2 = 32'hA000_0008;
    localparam logic [31:0] I3 = 32'hA000_000C;
    localparam logic [31:0] I4 = 32'hA000_0010;

    fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .br_taken   (br_taken),
        .br_pc      (br_pc),
        .br_imm16   (br_imm16),
        .stall      (stall),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_stall_cyc (perf_stall_cyc),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic addVec(input logic rst, input logic ack, input logic [31:0] rdata,
                          input logic br, input logic [31:0] brpc, input logic [15:0] imm,
                          input logic stl, input logic ereq, input logic [31:0] eaddr,
                          input logic evalid, input logic [31:0] einst, input logic [31:0] epc);
        vec_t v;
        v.rst = rst;  v.ack = ack;   v.rdata = rdata; v.br = br;
        v.brpc = brpc; v.imm = imm;  v.stl = stl;
        v.exp_req = ereq; v.exp_addr = eaddr; v.exp_valid = evalid;
        v.exp_inst = einst; v.exp_pc = epc;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        reset      = v.rst;
        imem_ack   = v.ack;
        imem_rdata = v.rdata;
        br_taken   = v.br;
        br_pc      = v.brpc;
        br_imm16   = v.imm;
        stall      = v.stl;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic idleInputs();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        br_taken   = 1'b0;
        br_pc      = 32'h0;
        br_imm16   = 16'h0;
        stall      = 1'b0;
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        reset        = 1'b0;
        idleInputs();

        //      rst ack rdata        br brpc          imm      stl  req addr          vld inst pc
        // reset, then single-cycle acks at 0, 4, 8
        addVec(1, 0, 32'h0,        0, 32'h0,        16'h0,    0,   0, 32'h0,         0, 32'h0, 32'h0);
        addVec(0, 1, I0,           0, 32'h0,        16'h0,    0,   1, 32'h0,         0, 32'h0, 32'h0);
        addVec(0, 1, I1,           0, 32'h0,        16'h0,    0,   1, 32'h4,         1, I0,    32'h0);
        addVec(0, 0, 32'h0,        0, 32'h0,        16'h0,    0,   1, 32'h8,         1, I1,    32'h4);
        addVec(0, 0, 32'h0,        0, 32'h0,        16'h0,    0,   1, 32'h8,         0, 32'h0, 32'h0);
        // reset, then 5-cycle stall fills the queue and parks in WAIT_SPACE
        addVec(1, 0, 32'h0,        0, 32'h0,        16'h0,    0,   0, 32'h0,         0, 32'h0, 32'h0);
        addVec(0, 1, I0,           0, 32'h0,        16'h0,    1,   1, 32'h0,         0, 32'h0, 32'h0);
        addVec(0, 1, I1,           0, 32'h0,        16'h0,    1,   1, 32'h4,         1, I0,    32'h0);
        addVec(0, 0, 32'h0,        0, 32'h0,        16'h0,    1,   0, 32'h8,         1, I0,    32'h0);
        addVec(0, 0, 32'h0,        0, 32'h0,        16'h0,    1,   0, 32'h8,         1, I0,    32'h0);
        addVec(0, 0, 32'h0,        0, 32'h0,        16'h0,    1,   0, 32'h8,         1, I0,    32'h0);
        addVec(0, 0, 32'h0,        0, 32'h0,        16'h0,    0,   0, 32'h8,         1, I0,    32'h0);
        // branch together with ack (stall ignored): data dropped, fetch at 0x0C
        addVec(0, 1, I2,           1, 32'h10,       16'hFFFE, 1,   1, 32'h8,         1, I1,    32'h4);
        addVec(0, 1, I3,           0, 32'h0,        16'h0,    1,   1, 32'hC,         0, 32'h0, 32'h0);
        addVec(0, 1, I4,           0, 32'h0,        16'h0,    1,   1, 32'h10,        1, I3,    32'hC);
        // branch from WAIT_SPACE with a full queue: flush, next address 0x0C
        addVec(0, 0, 32'h0,        1, 32'h10,       16'hFFFE, 1,   0, 32'h14,        1, I3,    32'hC);
        addVec(0, 0, 32'h0,        0, 32'h0,        16'h0,    0,   1, 32'hC,         0, 32'h0, 32'h0);
        // branch with request pending, ack 3 cycles later is discarded
        addVec(0, 0, 32'h0,        1, 32'h100,      16'h0003, 0,   1, 32'hC,         0, 32'h0, 32'h0);
        addVec(0, 0, 32'h0,        0, 32'h0,        16'h0,    0,   1, 32'hC,         0, 32'h0, 32'h0);
        addVec(0, 0, 32'h0,        0, 32'h0,        16'h0,    0,   1, 32'hC,         0, 32'h0, 32'h0);
        addVec(0, 1, 32'hDEADBEEF, 0, 32'h0,        16'h0,    0,   1, 32'hC,         0, 32'h0, 32'h0);
        // re-branch during DISCARD with a wrapping target (0xFFFFFFF0+4+16 = 0x4)
        addVec(0, 0, 32'h0,        1, 32'h200,      16'h0000, 0,   1, 32'h110,       0, 32'h0, 32'h0);
        addVec(0, 0, 32'h0,        1, 32'hFFFFFFF0, 16'h0004, 0,   1, 32'h110,       0, 32'h0, 32'h0);
        addVec(0, 1, 32'h11111111, 0, 32'h0,        16'h0,    0,   1, 32'h110,       0, 32'h0, 32'h0);
        addVec(0, 0, 32'h0,        0, 32'h0,        16'h0,    0,   1, 32'h4,         0, 32'h0, 32'h0);
        // reset in the middle of DISCARD
        addVec(0, 0, 32'h0,        1, 32'h100,      16'h0003, 0,   1, 32'h4,         0, 32'h0, 32'h0);
        addVec(1, 0, 32'h0,        0, 32'h0,        16'h0,    0,   0, 32'h0,         0, 32'h0, 32'h0);
        addVec(0, 1, I0,           0, 32'h0,        16'h0,    0,   1, 32'h0,         0, 32'h0, 32'h0);
        addVec(0, 0, 32'h0,        0, 32'h0,        16'h0,    0,   1, 32'h4,         1, I0,    32'h0);

        foreach (vecs[i]) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("v%0d.imem_req", i),   {31'h0, imem_req},   {31'h0, vecs[i].exp_req});
            checkOutput($sformatf("v%0d.imem_addr", i),  imem_addr,           vecs[i].exp_addr);
            checkOutput($sformatf("v%0d.inst_valid", i), {31'h0, inst_valid}, {31'h0, vecs[i].exp_valid});
            checkOutput($sformatf("v%0d.inst", i),       inst,                vecs[i].exp_inst);
            checkOutput($sformatf("v%0d.inst_pc", i),    inst_pc,             vecs[i].exp_pc);
        end

        // Streaming: ack every cycle, no stall; head trails the request by one word
        @(negedge clk);
        idleInputs();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k != 0) @(negedge clk);
            imem_ack = 1'b1;
            stall    = 1'b0;
            #1;
            imem_rdata = 32'hA000_0000 | imem_addr;
            checkOutput($sformatf("stream%0d.addr", k), imem_addr, 32'(4 * k));
            if (k >= 1) begin
                checkOutput($sformatf("stream%0d.valid", k), {31'h0, inst_valid}, 32'h1);
                checkOutput($sformatf("stream%0d.pc", k),    inst_pc,             32'(4 * (k - 1)));
                checkOutput($sformatf("stream%0d.inst", k),  inst,                32'hA000_0000 | 32'(4 * (k - 1)));
            end
        end

        // Stall with acks on demand until the queue fills and imem_req drops
        begin
            logic found;
            found = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                imem_ack = 1'b0;
                stall    = 1'b1;
                #1;
                if (!imem_req) begin
                    found = 1'b1;
                    break;
                end
                imem_ack   = 1'b1;
                imem_rdata = 32'hA000_0000 | imem_addr;
            end
            checkOutput("full.req_dropped", {31'h0, found}, 32'h1);
            checkOutput("full.addr",  imem_addr, 32'h24);
            checkOutput("full.pc",    inst_pc,   32'h1C);
            checkOutput("full.inst",  inst,      32'hA000_001C);
        end

        // Release the stall: two pops, then fetching resumes at 0x24
        @(negedge clk);
        stall = 1'b0;
        #1;
        checkOutput("drain0.pc", inst_pc, 32'h1C);
        @(negedge clk);
        #1;
        checkOutput("drain1.req",  {31'h0, imem_req}, 32'h1);
        checkOutput("drain1.addr", imem_addr,         32'h24);
        checkOutput("drain1.pc",   inst_pc,           32'h20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
